// File: rtl/call_meter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | call_meter_pkg : shared types, constants and helpers for the call meter    |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
package call_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TALK = 2'd1,
    ST_WARN = 2'd2,
    ST_CUT  = 2'd3
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int SEC_PER_MIN = 60;

  // Legal BCD words order exactly like binary words of the same width.
  function automatic logic bcd_ge(input logic [63:0] a, input logic [63:0] b);
    return a >= b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/call_meter_addsub.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bcd_addsub : combinational ripple BCD adder/subtractor, DIGITS digits      |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module bcd_addsub
  import call_meter_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                sub,
  output logic [4*DIGITS-1:0] result,
  output logic                carry
);

  logic [DIGITS:0] w_c;
  assign w_c[0] = 1'b0;
  assign carry  = w_c[DIGITS];

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_t w_a;
    bcd_digit_t w_b;
    logic [4:0] w_sum;
    logic [4:0] w_dif;
    assign w_a   = a[4*i +: 4];
    assign w_b   = b[4*i +: 4];
    assign w_sum = {1'b0, w_a} + {1'b0, w_b} + {4'd0, w_c[i]};
    // Bit 4 of the difference is its sign: a negative digit borrows ten.
    assign w_dif = {1'b0, w_a} - {1'b0, w_b} - {4'd0, w_c[i]};
    assign w_c[i+1] = sub ? w_dif[4] : (w_sum > 5'd9);
    assign result[4*i +: 4] = sub ? (w_dif[4] ? w_dif[3:0] + 4'd10 : w_dif[3:0])
                                  : ((w_sum > 5'd9) ? w_sum[3:0] + 4'd6 : w_sum[3:0]);
  end

endmodule
`default_nettype wire

// File: rtl/call_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | call_meter : per-call BCD billing meter with warn/cut and optional top-up  |
// | Option     : CALL_METER_RECHARGE_EN enables the recharge handshake         |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module call_meter
  import call_meter_pkg::*;
#(
  parameter int CLK_PER_SEC  = 1,
  parameter int MONEY_DIGITS = 3,
  parameter int TIME_DIGITS  = 3,
  parameter int NUM_TYPES    = 2,
  parameter logic [NUM_TYPES*4*MONEY_DIGITS-1:0] RATE_TABLE = {12'h006, 12'h003},
  parameter logic [4*MONEY_DIGITS-1:0] INIT_BALANCE = 12'h500,
  parameter int CUT_DELAY    = 15,
  localparam int TYPE_W = (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      calling,
  input  logic [TYPE_W-1:0]         call_type,
  input  logic                      recharge_valid,
  input  logic [4*MONEY_DIGITS-1:0] recharge_amt,
  output logic                      recharge_ready,
  output logic [4*MONEY_DIGITS-1:0] balance,
  output logic [4*TIME_DIGITS-1:0]  minutes,
  output logic                      write,
  output logic                      warn,
  output logic                      cut
);

  localparam int MW = 4*MONEY_DIGITS;
  localparam int TW = 4*TIME_DIGITS;
  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam int CW = $clog2(CUT_DELAY + 2);
  localparam logic [MW-1:0] BCD_MAX = {MONEY_DIGITS{4'h9}};

  state_t            r_state, w_state_next;
  logic [MW-1:0]     r_balance;
  logic [TW-1:0]     r_minutes;
  logic [TYPE_W-1:0] r_type;
  logic [PW-1:0]     r_presc;
  logic [5:0]        r_sec;
  logic [CW-1:0]     r_cut_cnt;
  logic              r_write, r_warn, r_cut, r_ready;

  logic [MW-1:0] w_rate, w_money_b, w_money_res, w_rech_bal;
  logic [TW-1:0] w_min_res;
  logic [CW-1:0] w_cut_next;
  logic w_money_sub, w_money_co, w_min_co, w_rech_acc, w_ready_next;
  logic w_tick, w_boundary, w_afford, w_start, w_charge;

  always_comb begin
    w_rate = '0;
    for (int i = 0; i < NUM_TYPES; i++) begin
      if (r_type == TYPE_W'(i)) w_rate = RATE_TABLE[i*MW +: MW];
    end
  end

  assign w_tick     = (r_presc == PW'(CLK_PER_SEC - 1));
  assign w_boundary = w_tick && (r_sec == 6'(SEC_PER_MIN - 1));
  assign w_afford   = bcd_ge(64'(r_balance), 64'(w_rate));
  assign w_cut_next = r_cut_cnt + CW'(w_tick);

`ifdef CALL_METER_RECHARGE_EN
  localparam logic READY_RST = 1'b1;
  assign w_rech_acc   = recharge_valid && r_ready;
  assign w_money_b    = w_rech_acc ? recharge_amt : w_rate;
  assign w_money_sub  = !w_rech_acc;
  assign w_ready_next = (w_state_next == ST_IDLE) || (w_state_next == ST_WARN);
  assign w_rech_bal   = w_money_co ? BCD_MAX : w_money_res;
`else
  localparam logic READY_RST = 1'b0;
  logic w_unused_rech;
  assign w_rech_acc    = 1'b0;
  assign w_money_b     = w_rate;
  assign w_money_sub   = 1'b1;
  assign w_ready_next  = 1'b0;
  assign w_rech_bal    = w_money_res;
  assign w_unused_rech = ^{recharge_valid, recharge_amt, w_money_co, BCD_MAX};
`endif

  bcd_addsub #(.DIGITS(MONEY_DIGITS)) u_money (
    .a(r_balance), .b(w_money_b), .sub(w_money_sub), .result(w_money_res), .carry(w_money_co)
  );

  bcd_addsub #(.DIGITS(TIME_DIGITS)) u_minutes (
    .a(r_minutes), .b(TW'(1)), .sub(1'b0), .result(w_min_res), .carry(w_min_co)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Hang-up outranks billing; a top-up in WARN defers the credit check a cycle.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_charge     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (calling) begin
          w_state_next = ST_TALK;
          w_start      = 1'b1;
        end
      end
      ST_TALK: begin
        if (!calling) w_state_next = ST_IDLE;
        else if (w_boundary) begin
          if (w_afford) w_charge = 1'b1;
          else          w_state_next = ST_WARN;
        end
      end
      ST_WARN: begin
        if (!calling) w_state_next = ST_IDLE;
        else if (w_rech_acc) w_state_next = ST_WARN;
        else if (w_afford) begin
          w_charge     = 1'b1;
          w_state_next = ST_TALK;
        end else if (w_cut_next >= CW'(CUT_DELAY)) w_state_next = ST_CUT;
      end
      ST_CUT: begin
        if (!calling) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_balance <= INIT_BALANCE;
      r_minutes <= '0;
      r_type    <= '0;
      r_presc   <= '0;
      r_sec     <= '0;
      r_cut_cnt <= '0;
      r_write   <= 1'b0;
      r_warn    <= 1'b0;
      r_cut     <= 1'b0;
      r_ready   <= READY_RST;
    end else begin
      r_write <= 1'b0;
      r_warn  <= (w_state_next == ST_WARN);
      r_cut   <= (w_state_next == ST_CUT);
      r_ready <= w_ready_next;
      if (w_start) begin
        r_type    <= call_type;
        r_minutes <= '0;
        r_presc   <= '0;
        r_sec     <= '0;
        r_cut_cnt <= '0;
      end else if (r_state == ST_TALK || r_state == ST_WARN) begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
        if (r_state == ST_TALK && w_tick) r_sec <= w_boundary ? '0 : r_sec + 1'b1;
        if (r_state == ST_WARN) r_cut_cnt <= w_cut_next;
      end
      if (w_charge) begin
        r_balance <= w_money_res;
        r_cut_cnt <= '0;
        if (!w_min_co) begin
          r_minutes <= w_min_res;
          r_write   <= 1'b1;
        end
      end else if (w_rech_acc) begin
        r_balance <= w_rech_bal;
      end
    end
  end

  assign recharge_ready = r_ready;
  assign balance        = r_balance;
  assign minutes        = r_minutes;
  assign write          = r_write;
  assign warn           = r_warn;
  assign cut            = r_cut;

endmodule
`default_nettype wire

// File: tb/tb_call_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_call_meter : directed + random bench for call_meter (default params)    |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module tb_call_meter;

`ifdef CALL_METER_RECHARGE_EN
  localparam bit RECHARGE_EN = 1'b1;
`else
  localparam bit RECHARGE_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_TALK = 1, M_WARN = 2, M_CUT = 3;
  localparam int CUT_DELAY = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        calling = 1'b0;
  logic [0:0]  call_type = 1'b0;
  logic        recharge_valid = 1'b0;
  logic [11:0] recharge_amt = 12'h000;
  logic        recharge_ready, write, warn, cut;
  logic [11:0] balance, minutes;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: money in cents, minutes as an integer, call phase by name.
  int m_bal = 500, m_min = 0, m_mode = M_IDLE, m_typ = 0, m_talk = 0, m_warn = 0;
  bit m_write = 1'b0;

  call_meter dut (
    .clk(clk), .rst(rst), .calling(calling), .call_type(call_type),
    .recharge_valid(recharge_valid), .recharge_amt(recharge_amt),
    .recharge_ready(recharge_ready), .balance(balance), .minutes(minutes),
    .write(write), .warn(warn), .cut(cut)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int from_bcd(input logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic int rate_of(input int t);
    return (t == 0) ? 3 : ((t == 1) ? 6 : 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic charge();
    m_bal -= rate_of(m_typ);
    if (m_min < 999) begin
      m_min++;
      m_write = 1'b1;
    end
  endtask

  task automatic model_edge();
    bit acc;
    m_write = 1'b0;
    if (rst) begin
      m_bal = 500; m_min = 0; m_mode = M_IDLE;
      return;
    end
    acc = RECHARGE_EN && recharge_valid && (m_mode == M_IDLE || m_mode == M_WARN);
    if (acc) m_bal = (m_bal + from_bcd(recharge_amt) > 999) ? 999 : m_bal + from_bcd(recharge_amt);
    if (m_mode == M_IDLE) begin
      if (calling) begin
        m_mode = M_TALK; m_typ = int'(call_type); m_min = 0; m_talk = 0;
      end
    end else if (!calling) begin
      m_mode = M_IDLE;
    end else if (m_mode == M_TALK) begin
      m_talk++;
      if (m_talk % 60 == 0) begin
        if (m_bal >= rate_of(m_typ)) charge();
        else begin
          m_mode = M_WARN; m_warn = 0;
        end
      end
    end else if (m_mode == M_WARN) begin
      m_warn++;
      if (!acc) begin
        if (m_bal >= rate_of(m_typ)) begin
          charge(); m_mode = M_TALK;
        end else if (m_warn >= CUT_DELAY) m_mode = M_CUT;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("balance", 32'(balance), 32'(to_bcd(m_bal)));
    check("minutes", 32'(minutes), 32'(to_bcd(m_min)));
    check("write", 32'(write), 32'(m_write));
    check("warn", 32'(warn), 32'(m_mode == M_WARN));
    check("cut", 32'(cut), 32'(m_mode == M_CUT));
    check("ready", 32'(recharge_ready), 32'(RECHARGE_EN && (m_mode == M_IDLE || m_mode == M_WARN)));
  endtask

  initial begin
    int nw;
    // Reset state
    step(); step();
    check("rst_balance", 32'(balance), 32'h500);
    check("rst_minutes", 32'(minutes), 32'h000);
    check("rst_flags", 32'({write, warn, cut}), 32'd0);
    check("rst_ready", 32'(recharge_ready), 32'(RECHARGE_EN));
    rst = 1'b0;

    // Type-0 call for three minutes
    calling = 1'b1; call_type = 1'b0; step();
    nw = 0;
    for (int i = 1; i <= 180; i++) begin
      step();
      if (write) nw++;
      if (i == 60) check("write_at_60", 32'(write), 32'd1);
    end
    check("t0_writes", 32'(nw), 32'd3);
    check("t0_balance", 32'(balance), 32'h491);
    check("t0_minutes", 32'(minutes), 32'h003);
    calling = 1'b0; step();

    // Hang up exactly on the first minute boundary
    calling = 1'b1; call_type = 1'b1; step();
    for (int i = 1; i <= 59; i++) step();
    calling = 1'b0; step();
    check("drop60_write", 32'(write), 32'd0);
    check("drop60_balance", 32'(balance), 32'h491);
    check("drop60_minutes", 32'(minutes), 32'h000);

    // Drain credit with type 1 until warning, then wait for cut
    calling = 1'b1; step();
    nw = 0;
    for (int n = 0; n < 6000 && warn !== 1'b1; n++) begin
      step();
      if (write) nw++;
    end
    check("drain_warn", 32'(warn), 32'd1);
    check("drain_writes", 32'(nw), 32'd81);
    check("drain_balance", 32'(balance), 32'h005);
    check("drain_minutes", 32'(minutes), 32'h081);
    for (int j = 1; j <= 14; j++) step();
    check("grace_no_cut", 32'({warn, cut}), 32'b10);
    step();
    check("cut_rise", 32'({warn, cut}), 32'b01);
    calling = 1'b0; step();
    check("cut_release", 32'({warn, cut}), 32'b00);

    // Reset in the middle of a warning
    calling = 1'b1; step();
    for (int i = 1; i <= 60; i++) step();
    check("rewarn", 32'(warn), 32'd1);
    step(); step();
    rst = 1'b1; calling = 1'b0; step();
    check("midrst_balance", 32'(balance), 32'h500);
    check("midrst_flags", 32'({write, warn, cut}), 32'd0);
    check("midrst_minutes", 32'(minutes), 32'h000);
    rst = 1'b0; step();

    // Drain again and top up on the fifth warning cycle
    calling = 1'b1; call_type = 1'b1; step();
    nw = 0;
    for (int n = 0; n < 6000 && warn !== 1'b1; n++) begin
      step();
      if (write) nw++;
    end
    check("drain2_writes", 32'(nw), 32'd83);
    check("drain2_balance", 32'(balance), 32'h002);
    for (int j = 1; j <= 4; j++) step();
    check("warn_ready", 32'(recharge_ready), 32'(RECHARGE_EN));
    recharge_valid = 1'b1; recharge_amt = 12'h100; step();
    check("topup_balance", 32'(balance), RECHARGE_EN ? 32'h102 : 32'h002);
    recharge_valid = 1'b0; step();
    check("recover_balance", 32'(balance), RECHARGE_EN ? 32'h096 : 32'h002);
    check("recover_write", 32'(write), 32'(RECHARGE_EN));
    check("recover_warn", 32'(warn), 32'(!RECHARGE_EN));
    calling = 1'b0; step();

    // Idle top-up saturates; top-up refused while talking
    recharge_valid = 1'b1; recharge_amt = 12'h950; step();
    check("sat_balance", 32'(balance), RECHARGE_EN ? 32'h999 : 32'h002);
    recharge_valid = 1'b0; calling = 1'b1; call_type = 1'b0; step();
    recharge_valid = 1'b1; recharge_amt = 12'h100; step();
    check("talk_ready", 32'(recharge_ready), 32'd0);
    check("talk_balance", 32'(balance), RECHARGE_EN ? 32'h999 : 32'h002);
    recharge_valid = 1'b0; calling = 1'b0; step();

    // Random traffic against the model
    for (int n = 0; n < 6000; n++) begin
      if ($urandom_range(0, 149) == 0) calling = !calling;
      call_type      = 1'($urandom_range(0, 1));
      recharge_valid = ($urandom_range(0, 39) == 0);
      recharge_amt   = to_bcd(int'($urandom_range(0, 30)));
      rst            = ($urandom_range(0, 2999) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
